// File: rtl/rom_read_arbiter_if.sv
// Bundle of the requester-side and ROM-side signals of the ROM read arbiter.
// The slave modport is the arbiter's view; the master modport is the view
// of the surrounding environment (requesters plus the ROM itself).
interface rom_read_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic                    hold;
    logic [N_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]       rom_addr;
    logic [DATA_W-1:0]       rom_data;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data;
    logic [CNT_W-1:0]        gnt_count;

    modport master (
        output req, req_addr, hold, rom_data,
        input  gnt, rom_addr, rsp_valid, rsp_data, gnt_count
    );

    modport slave (
        input  req, req_addr, hold, rom_data,
        output gnt, rom_addr, rsp_valid, rsp_data, gnt_count
    );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one synchronous-read ROM among N_REQ requesters.
// A grant in cycle T drives rom_addr in T+1 and the response (rsp_valid plus
// the ROM data passed straight through) in T+2. hold blocks new grants only;
// reads already in flight always finish unless reset intervenes.
module rom_read_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    rom_read_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

    logic [PTR_W-1:0]  r_ptr;
    logic [ADDR_W-1:0] r_romAddr;
    logic [N_REQ-1:0]  r_tag1;
    logic [N_REQ-1:0]  r_rspValid;
    logic [CNT_W-1:0]  r_gntCount;

    logic [PTR_W-1:0]  w_winner;
    logic [PTR_W-1:0]  w_nextPtr;
    logic [PTR_W-1:0]  w_idx;
    logic              w_found;
    logic              w_grant;
    logic [N_REQ-1:0]  w_gnt;
    logic [ADDR_W-1:0] w_winAddr;

    // Pointer plus offset, wrapped so that values >= N_REQ never appear.
    function automatic logic [PTR_W-1:0] wrapAdd(input logic [PTR_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return s[PTR_W-1:0];
    endfunction

    // Scan requesters starting at the priority pointer and pick the first active one.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = wrapAdd(r_ptr, k);
            if (!w_found && bus.req[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    // Qualify the winner with hold and reset, and derive the grant side effects.
    always_comb begin
        w_grant   = w_found && !bus.hold && reset_n;
        w_gnt     = '0;
        w_gnt[w_winner] = w_grant;
        w_nextPtr = (w_winner == LAST_IDX) ? '0 : w_winner + 1'b1;
        w_winAddr = bus.req_addr[int'(w_winner)*ADDR_W +: ADDR_W];
    end

    // Grant-side state: priority pointer, ROM address and saturating grant counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr      <= '0;
            r_romAddr  <= '0;
            r_gntCount <= '0;
        end else if (w_grant) begin
            r_ptr     <= w_nextPtr;
            r_romAddr <= w_winAddr;
            if (r_gntCount != '1) begin
                r_gntCount <= r_gntCount + 1'b1;
            end
        end
    end

    // Two-stage tag pipeline that follows each read through the ROM, never stalled by hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag1     <= '0;
            r_rspValid <= '0;
        end else begin
            r_tag1     <= w_gnt;
            r_rspValid <= r_tag1;
        end
    end

    assign bus.gnt       = w_gnt;
    assign bus.rom_addr  = r_romAddr;
    assign bus.rsp_valid = r_rspValid;
    assign bus.rsp_data  = bus.rom_data;
    assign bus.gnt_count = r_gntCount;
endmodule

// File: tb/tb_rom_read_arbiter.sv
// Testbench for rom_read_arbiter: a vector table of per-cycle inputs and
// expected grants, plus hand-written reset and saturation sequences.
// Responses are predicted into a scoreboard queue when a grant is expected
// and compared two cycles later.
module tb_rom_read_arbiter;
    localparam int N_REQ  = 4;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 4;
    localparam int CNT_W  = 4;

    typedef struct {
        logic        rstN;
        logic [3:0]  req;
        logic [31:0] addr;
        logic        hold;
        logic [3:0]  expGnt;
    } vec_t;

    typedef struct {
        int         due;
        logic [3:0] valid;
        logic [3:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic reset_n;

    vec_t vecs[$];
    rsp_t sb[$];
    int   testsRun = 0;
    int   testsFailed = 0;
    int   cycle = 0;
    logic [7:0] expRomAddr;
    logic [3:0] expCount;

    rom_read_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    rom_read_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] romOf(input logic [7:0] a);
        return a[3:0] ^ a[7:4];
    endfunction

    // Registered ROM model feeding the arbiter's data input.
    always @(posedge clk) bus.rom_data <= romOf(bus.rom_addr);

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, act, exp);
        end
    endtask

    function automatic void addVec(input logic rstN, input logic [3:0] req, input logic [31:0] addr,
                                   input logic hold, input logic [3:0] expGnt);
        vec_t v;
        v.rstN = rstN; v.req = req; v.addr = addr; v.hold = hold; v.expGnt = expGnt;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input vec_t v);
        reset_n      = v.rstN;
        bus.req      = v.req;
        bus.req_addr = v.addr;
        bus.hold     = v.hold;
        if (!v.rstN) begin
            sb.delete();
            expRomAddr = 8'h00;
            expCount   = 4'h0;
        end
    endtask

    task automatic checkOutput(input vec_t v);
        rsp_t r;
        int   w;
        logic [7:0] a;
        compare("gnt", 32'(bus.gnt), 32'(v.expGnt));
        compare("rom_addr", 32'(bus.rom_addr), 32'(expRomAddr));
        compare("gnt_count", 32'(bus.gnt_count), 32'(expCount));
        if (sb.size() > 0 && sb[0].due == cycle) begin
            r = sb.pop_front();
            compare("rsp_valid", 32'(bus.rsp_valid), 32'(r.valid));
            compare("rsp_data", 32'(bus.rsp_data), 32'(r.data));
        end else begin
            compare("rsp_valid_idle", 32'(bus.rsp_valid), 32'h0);
        end
        if (v.expGnt != 4'b0000) begin
            w = 0;
            for (int k = 0; k < N_REQ; k++) begin
                if (v.expGnt[k]) w = k;
            end
            a = v.addr[w*8 +: 8];
            r.due = cycle + 2; r.valid = v.expGnt; r.data = romOf(a);
            sb.push_back(r);
            expRomAddr = a;
            if (expCount != 4'hF) expCount = expCount + 4'h1;
        end
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(v);
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic runRow(input logic rstN, input logic [3:0] req, input logic [31:0] addr,
                          input logic hold, input logic [3:0] expGnt);
        vec_t v;
        v.rstN = rstN; v.req = req; v.addr = addr; v.hold = hold; v.expGnt = expGnt;
        runVec(v);
    endtask

    initial begin
        logic [31:0] addrs;
        logic [7:0]  b;
        addrs = 32'h34231201;

        reset_n      = 1'b0;
        bus.req      = '0;
        bus.req_addr = '0;
        bus.hold     = 1'b0;
        expRomAddr   = 8'h00;
        expCount     = 4'h0;

        // Reset state, including requests that must not be granted during reset.
        addVec(1'b0, 4'b0000, addrs, 1'b0, 4'b0000);
        addVec(1'b0, 4'b1111, addrs, 1'b0, 4'b0000);
        // Single request from requester 2, address 0x3A.
        addVec(1'b1, 4'b0100, 32'h003A0000, 1'b0, 4'b0100);
        addVec(1'b1, 4'b0000, 32'h003A0000, 1'b0, 4'b0000);
        addVec(1'b1, 4'b0000, 32'h003A0000, 1'b0, 4'b0000);
        addVec(1'b1, 4'b0000, 32'h003A0000, 1'b0, 4'b0000);
        // All four requesting continuously from reset.
        addVec(1'b0, 4'b0000, addrs, 1'b0, 4'b0000);
        addVec(1'b1, 4'b1111, addrs, 1'b0, 4'b0001);
        addVec(1'b1, 4'b1111, addrs, 1'b0, 4'b0010);
        addVec(1'b1, 4'b1111, addrs, 1'b0, 4'b0100);
        addVec(1'b1, 4'b1111, addrs, 1'b0, 4'b1000);
        addVec(1'b1, 4'b1111, addrs, 1'b0, 4'b0001);
        addVec(1'b1, 4'b0000, addrs, 1'b0, 4'b0000);
        addVec(1'b1, 4'b0000, addrs, 1'b0, 4'b0000);
        addVec(1'b1, 4'b0000, addrs, 1'b0, 4'b0000);
        // Fairness and pointer wrap after a grant to requester 3.
        addVec(1'b1, 4'b0010, addrs, 1'b0, 4'b0010);
        addVec(1'b1, 4'b1010, addrs, 1'b0, 4'b1000);
        addVec(1'b1, 4'b1010, addrs, 1'b0, 4'b0010);
        addVec(1'b1, 4'b1001, addrs, 1'b0, 4'b1000);
        addVec(1'b1, 4'b1001, addrs, 1'b0, 4'b0001);
        addVec(1'b1, 4'b0000, addrs, 1'b0, 4'b0000);
        addVec(1'b1, 4'b0000, addrs, 1'b0, 4'b0000);
        // Hold for three cycles with a grant in flight, then release.
        addVec(1'b1, 4'b0001, addrs, 1'b0, 4'b0001);
        addVec(1'b1, 4'b0001, addrs, 1'b1, 4'b0000);
        addVec(1'b1, 4'b0001, addrs, 1'b1, 4'b0000);
        addVec(1'b1, 4'b0001, addrs, 1'b1, 4'b0000);
        addVec(1'b1, 4'b0001, addrs, 1'b0, 4'b0001);
        // Back-to-back grants whose responses land while hold is high.
        addVec(1'b1, 4'b0011, addrs, 1'b0, 4'b0010);
        addVec(1'b1, 4'b0011, addrs, 1'b0, 4'b0001);
        addVec(1'b1, 4'b0011, addrs, 1'b1, 4'b0000);
        addVec(1'b1, 4'b0011, addrs, 1'b1, 4'b0000);
        addVec(1'b1, 4'b0000, addrs, 1'b0, 4'b0000);
        addVec(1'b1, 4'b0000, addrs, 1'b0, 4'b0000);

        @(posedge clk);
        #1;
        foreach (vecs[i]) runVec(vecs[i]);

        // Reset asserted the cycle after a grant: the response must vanish.
        runRow(1'b1, 4'b0100, addrs, 1'b0, 4'b0100);
        runRow(1'b0, 4'b0000, addrs, 1'b0, 4'b0000);
        runRow(1'b0, 4'b0000, addrs, 1'b0, 4'b0000);
        runRow(1'b1, 4'b1111, addrs, 1'b0, 4'b0001);
        runRow(1'b1, 4'b0000, addrs, 1'b0, 4'b0000);
        runRow(1'b1, 4'b0000, addrs, 1'b0, 4'b0000);
        runRow(1'b1, 4'b0000, addrs, 1'b0, 4'b0000);

        // Twenty consecutive grants from reset to saturate the 4-bit counter.
        runRow(1'b0, 4'b0000, addrs, 1'b0, 4'b0000);
        for (int i = 0; i < 20; i++) begin
            b = 8'(i);
            runRow(1'b1, 4'b1111, {b + 8'h30, b + 8'h20, b + 8'h10, b}, 1'b0,
                   4'b0001 << (i % 4));
        end
        runRow(1'b1, 4'b0000, addrs, 1'b0, 4'b0000);
        runRow(1'b1, 4'b0000, addrs, 1'b0, 4'b0000);
        runRow(1'b1, 4'b0000, addrs, 1'b0, 4'b0000);
        compare("gnt_count_sat", 32'(bus.gnt_count), 32'd15);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
